axis_tx_arbiter: RTL and testbench

AXIS_TX_ARBITER -- requirements
Module: axis_tx_arbiter

---
 rtl/axis_tx_arbiter_pkg.sv | 25 ++
 rtl/axis_tx_arbiter_ifg.sv | 38 +++
 rtl/axis_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_axis_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester AXIS transmit arbiter.
package axis_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } arb_state_e;

  localparam int unsigned DEFAULT_IFG_CYCLES = 48;
  localparam int unsigned FRAME_COUNT_WIDTH  = 16;
  localparam int unsigned IFG_COUNT_WIDTH    = 8;

  // Round-robin pick: on contention the requester not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
    logic winner;
    if (req == 2'b11) begin
      winner = ~last_owner;
    end else begin
      winner = req[1];
    end
    return winner;
  endfunction

endpackage

// File: rtl/axis_tx_arbiter_ifg.sv
// Inter-frame gap timer: load with the gap length minus one, count down while enabled.
module ifg_timer
  import axis_tx_arbiter_pkg::*;
#(
  parameter int unsigned IfgCycles = DEFAULT_IFG_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [IFG_COUNT_WIDTH-1:0] LoadVal =
      (IfgCycles == 0) ? '0 : IFG_COUNT_WIDTH'(IfgCycles - 1);

  logic [IFG_COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - IFG_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/axis_tx_arbiter.sv
// Two-input AXIS frame arbiter with round-robin grant, whole-frame locking and
// a forced inter-frame gap on the shared output.
module axis_tx_arbiter
  import axis_tx_arbiter_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = DEFAULT_IFG_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   saxis0_tdata,
  input  logic                         saxis0_tvalid,
  output logic                         saxis0_tready,
  input  logic                         saxis0_tlast,
  input  logic [7:0]                   saxis1_tdata,
  input  logic                         saxis1_tvalid,
  output logic                         saxis1_tready,
  input  logic                         saxis1_tlast,
  output logic [7:0]                   maxis_tdata,
  output logic                         maxis_tvalid,
  input  logic                         maxis_tready,
  output logic                         maxis_tlast,
  output logic [1:0]                   grant,
  output logic [FRAME_COUNT_WIDTH-1:0] frames0,
  output logic [FRAME_COUNT_WIDTH-1:0] frames1
);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic [FRAME_COUNT_WIDTH-1:0] frames0_q, frames0_d;
  logic [FRAME_COUNT_WIDTH-1:0] frames1_q, frames1_d;
  logic timer_load, timer_en, timer_done;
  logic last_beat;

  ifg_timer #(
    .IfgCycles(IFG_CYCLES)
  ) u_ifg_timer (
    .clk_i (clock),
    .rst_i (reset),
    .load_i(timer_load),
    .en_i  (timer_en),
    .done_o(timer_done)
  );

  // Output mux: only the owner sees backpressure, and only while granted.
  always_comb begin
    maxis_tdata   = '0;
    maxis_tvalid  = 1'b0;
    maxis_tlast   = 1'b0;
    saxis0_tready = 1'b0;
    saxis1_tready = 1'b0;
    grant         = 2'b00;
    if (state_q == StGrant) begin
      if (owner_q) begin
        maxis_tdata   = saxis1_tdata;
        maxis_tvalid  = saxis1_tvalid;
        maxis_tlast   = saxis1_tlast;
        saxis1_tready = maxis_tready;
        grant         = 2'b10;
      end else begin
        maxis_tdata   = saxis0_tdata;
        maxis_tvalid  = saxis0_tvalid;
        maxis_tlast   = saxis0_tlast;
        saxis0_tready = maxis_tready;
        grant         = 2'b01;
      end
    end
  end

  assign last_beat = maxis_tvalid & maxis_tready & maxis_tlast;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    frames0_d  = frames0_q;
    frames1_d  = frames1_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (saxis0_tvalid || saxis1_tvalid) begin
          owner_d = rr_pick({saxis1_tvalid, saxis0_tvalid}, last_q);
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (last_beat) begin
          if (owner_q) begin
            frames1_d = frames1_q + FRAME_COUNT_WIDTH'(1);
          end else begin
            frames0_d = frames0_q + FRAME_COUNT_WIDTH'(1);
          end
          last_d = owner_q;
          if (IFG_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d    = StGap;
            timer_load = 1'b1;
          end
        end
      end
      StGap: begin
        timer_en = 1'b1;
        if (timer_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      frames0_q <= '0;
      frames1_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
    end
  end

  assign frames0 = frames0_q;
  assign frames1 = frames1_q;

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Scoreboard bench for axis_tx_arbiter: drivers push expected beats per requester,
// a negedge monitor pops and compares on every output handshake.
module tb_axis_tx_arbiter;

  localparam int unsigned Ifg = 48;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  s_tdata  [2];
  logic        s_tvalid [2];
  logic        s_tlast  [2];
  logic        s_tready [2];
  logic [7:0]  maxis_tdata;
  logic        maxis_tvalid, maxis_tready, maxis_tlast;
  logic [1:0]  grant;
  logic [15:0] frames0, frames1;

  int n_pass  = 0;
  int n_total = 0;
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];
  int order_q[$];
  int gap_q[$];
  logic rnd_tready = 1'b0;

  always #5 clock = ~clock;

  axis_tx_arbiter #(
    .IFG_CYCLES(Ifg)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .saxis0_tdata (s_tdata[0]),
    .saxis0_tvalid(s_tvalid[0]),
    .saxis0_tready(s_tready[0]),
    .saxis0_tlast (s_tlast[0]),
    .saxis1_tdata (s_tdata[1]),
    .saxis1_tvalid(s_tvalid[1]),
    .saxis1_tready(s_tready[1]),
    .saxis1_tlast (s_tlast[1]),
    .maxis_tdata  (maxis_tdata),
    .maxis_tvalid (maxis_tvalid),
    .maxis_tready (maxis_tready),
    .maxis_tlast  (maxis_tlast),
    .grant        (grant),
    .frames0      (frames0),
    .frames1      (frames1)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor / scoreboard
  logic in_frame  = 1'b0;
  logic cur_owner = 1'b0;
  logic counting  = 1'b0;
  int   idle_cnt  = 0;

  always @(negedge clock) begin
    logic own;
    logic [8:0] e;
    int sz;
    if (reset) begin
      in_frame = 1'b0;
      counting = 1'b0;
    end else begin
      own = grant[1];
      if (grant == 2'b00) begin
        chk("idle_quiet", 32'({maxis_tvalid, s_tready[0], s_tready[1]}), 0);
      end else begin
        chk("grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 1);
        chk("owner_tready", 32'(s_tready[own]), 32'(maxis_tready));
        chk("other_tready", 32'(s_tready[!own]), 0);
        if (in_frame) chk("grant_hold", 32'(own), 32'(cur_owner));
      end
      if (counting) begin
        if (maxis_tvalid) begin
          gap_q.push_back(idle_cnt);
          counting = 1'b0;
        end else begin
          idle_cnt++;
        end
      end
      if (grant != 2'b00 && maxis_tvalid && maxis_tready) begin
        if (!in_frame) begin
          order_q.push_back(int'(own));
          cur_owner = own;
          in_frame  = 1'b1;
        end
        sz = own ? exp1.size() : exp0.size();
        chk("beat_expected", 32'(sz != 0), 1);
        if (sz != 0) begin
          e = own ? exp1.pop_front() : exp0.pop_front();
          chk("beat_data", 32'({maxis_tlast, maxis_tdata}), 32'(e));
        end
        if (maxis_tlast) begin
          in_frame = 1'b0;
          counting = 1'b1;
          idle_cnt = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rnd_tready) maxis_tready = 1'($urandom_range(0, 1));
  end

  // Present the current beat of requester r until it is accepted (bounded).
  task automatic wait_beat(input int r, output logic ok);
    logic hs;
    int waited;
    hs = 1'b0;
    waited = 0;
    while (!hs && waited < 4000) begin
      @(negedge clock);
      hs = s_tvalid[r] && s_tready[r];
      @(posedge clock);
      #1;
      waited++;
    end
    if (!hs) chk("beat_timeout", 32'(waited), 0);
    ok = hs;
  endtask

  task automatic send_frame(input int r, input int len, input logic [7:0] first,
                            input logic [7:0] step, input int stall_at, input int stall_len);
    logic [7:0] d;
    logic ok;
    d = first;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        s_tvalid[r] = 1'b0;
        repeat (stall_len) begin
          @(posedge clock);
          #1;
        end
      end
      if (r == 0) exp0.push_back({i == len - 1, d});
      else exp1.push_back({i == len - 1, d});
      s_tdata[r]  = d;
      s_tlast[r]  = (i == len - 1);
      s_tvalid[r] = 1'b1;
      wait_beat(r, ok);
      if (!ok) break;
      d = d + step;
    end
    s_tvalid[r] = 1'b0;
    s_tlast[r]  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    order_q.delete();
    gap_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic ok;
    reset = 1'b1;
    maxis_tready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      s_tdata[r]  = 8'h00;
      s_tvalid[r] = 1'b0;
      s_tlast[r]  = 1'b0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_grant", 32'(grant), 0);
    chk("reset_tvalid", 32'(maxis_tvalid), 0);
    chk("reset_tready", 32'({s_tready[0], s_tready[1]}), 0);
    chk("reset_frames0", 32'(frames0), 0);
    chk("reset_frames1", 32'(frames1), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single 3-byte frame from requester 0, grant one cycle after tvalid
    fork
      send_frame(0, 3, 8'h11, 8'h11, -1, 0);
      begin
        @(negedge clock);
        chk("grant_arb_cycle", 32'(grant), 0);
        @(negedge clock);
        chk("grant_cycle1", 32'(grant), 32'b01);
      end
    join
    chk("t1_frames0", 32'(frames0), 1);
    chk("t1_frames1", 32'(frames1), 0);

    // Contention from IDLE: strict alternation 0,1,0,1 with full gaps
    do_reset();
    fork
      begin
        send_frame(0, 2, 8'h01, 8'h01, -1, 0);
        send_frame(0, 2, 8'h03, 8'h01, -1, 0);
      end
      begin
        send_frame(1, 2, 8'h81, 8'h01, -1, 0);
        send_frame(1, 2, 8'h83, 8'h01, -1, 0);
      end
    join
    chk("rr_order_len", 32'(order_q.size()), 4);
    if (order_q.size() == 4)
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(order_q[i]), 32'(i % 2));
    chk("rr_gap_len", 32'(gap_q.size()), 3);
    foreach (gap_q[i]) chk("rr_gap", 32'(gap_q[i]), Ifg + 1);

    // Back-to-back frames from requester 1: idle gap of IFG+1 cycles
    do_reset();
    send_frame(1, 3, 8'h20, 8'h01, -1, 0);
    send_frame(1, 3, 8'h30, 8'h01, -1, 0);
    chk("b2b_gap_len", 32'(gap_q.size()), 1);
    if (gap_q.size() == 1) chk("b2b_gap", 32'(gap_q[0]), Ifg + 1);

    // Owner stalls mid-frame while the other requester waits
    do_reset();
    fork
      send_frame(0, 6, 8'h40, 8'h01, 2, 5);
      begin
        @(posedge clock);
        #1;
        send_frame(1, 2, 8'hA0, 8'h01, -1, 0);
      end
      begin
        repeat (5) @(negedge clock);
        chk("stall_grant", 32'(grant), 32'b01);
        chk("stall_tvalid", 32'(maxis_tvalid), 0);
        chk("stall_other_tready", 32'(s_tready[1]), 0);
      end
    join
    chk("stall_order_len", 32'(order_q.size()), 2);
    if (order_q.size() == 2) begin
      chk("stall_order0", 32'(order_q[0]), 0);
      chk("stall_order1", 32'(order_q[1]), 1);
    end

    // Random backpressure, 100 random frames per requester
    do_reset();
    rnd_tready = 1'b1;
    fork
      for (int f = 0; f < 100; f++)
        send_frame(0, $urandom_range(1, 24), 8'($urandom), 8'($urandom_range(1, 255)),
                   $urandom_range(0, 30), $urandom_range(0, 3));
      for (int f = 0; f < 100; f++)
        send_frame(1, $urandom_range(1, 24), 8'($urandom), 8'($urandom_range(1, 255)),
                   $urandom_range(0, 30), $urandom_range(0, 3));
    join
    rnd_tready = 1'b0;
    @(posedge clock);
    #1;
    maxis_tready = 1'b1;
    chk("rand_frames0", 32'(frames0), 100);
    chk("rand_frames1", 32'(frames1), 100);
    chk("rand_frames_sum", 32'(frames0) + 32'(frames1), 200);
    chk("rand_exp_empty", 32'(exp0.size() + exp1.size()), 0);

    // Reset while byte 2 of a frame is on the bus
    exp0.push_back({1'b0, 8'hAA});
    s_tdata[0]  = 8'hAA;
    s_tlast[0]  = 1'b0;
    s_tvalid[0] = 1'b1;
    wait_beat(0, ok);
    s_tdata[0] = 8'hBB;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    s_tvalid[0] = 1'b0;
    order_q.delete();
    @(negedge clock);
    chk("abort_grant", 32'(grant), 0);
    chk("abort_tvalid", 32'(maxis_tvalid), 0);
    chk("abort_frames0", 32'(frames0), 0);
    chk("abort_frames1", 32'(frames1), 0);
    chk("abort_exp_empty", 32'(exp0.size()), 0);
    @(posedge clock);
    #1;
    fork
      send_frame(1, 1, 8'h5A, 8'h01, -1, 0);
      send_frame(0, 1, 8'hA5, 8'h01, -1, 0);
    join
    chk("post_reset_order_len", 32'(order_q.size()), 2);
    if (order_q.size() == 2) begin
      chk("post_reset_first", 32'(order_q[0]), 0);
      chk("post_reset_second", 32'(order_q[1]), 1);
    end
    chk("post_reset_frames0", 32'(frames0), 1);
    chk("post_reset_frames1", 32'(frames1), 1);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
